// File: rtl/cursor_step_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cursor_step_ctrl_pkg
// Brief    : Shared types and constants for the cursor step sequencer:
//            FSM state encoding, button/direction codes, grid bounds.
// Options  : CURSOR_AUTO_REPEAT_EN (used by cursor_step_ctrl)
// Revision : 1.0  initial release
// ============================================================================
package cursor_step_ctrl_pkg;

  localparam int DEF_COUNT_WIRES = 2;

  // Button index layout of the internal level/edge vectors
  localparam int NUM_BTNS = 5;
  localparam int BTN_SEL  = 4;

  typedef enum logic [2:0] {
    S_ROW    = 3'd0,
    S_COL    = 3'd1,
    S_PULSE  = 3'd2,
    S_GAP    = 3'd3,
    S_COMMIT = 3'd4
  } state_e;

  // Direction codes double as indices into the button vectors
  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  function automatic int grid_max(input int width);
    return (1 << width) - 1;
  endfunction

  localparam int GRID_MAX = grid_max(DEF_COUNT_WIRES);

endpackage
`default_nettype wire

// File: rtl/cursor_step_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : cursor_step_ctrl_if
// Brief    : Button inputs and step-command outputs of the cursor sequencer.
//            master = button/lock source and counter side, slave = sequencer.
// Revision : 1.0  initial release
// ============================================================================
interface cursor_step_ctrl_if
  import cursor_step_ctrl_pkg::*;
#(
  parameter int COUNT_WIRES = DEF_COUNT_WIRES
) ();

  logic                   btn_up;
  logic                   btn_down;
  logic                   btn_left;
  logic                   btn_right;
  logic                   btn_sel;
  logic                   lock;
  logic                   row_en;
  logic                   col_en;
  logic                   add_n;
  logic                   fire;
  logic [COUNT_WIRES-1:0] row_pos;
  logic [COUNT_WIRES-1:0] col_pos;
  logic                   stage_col;
  logic                   commit;

  modport master (
    output btn_up, btn_down, btn_left, btn_right, btn_sel, lock,
    input  row_en, col_en, add_n, fire, row_pos, col_pos, stage_col, commit
  );

  modport slave (
    input  btn_up, btn_down, btn_left, btn_right, btn_sel, lock,
    output row_en, col_en, add_n, fire, row_pos, col_pos, stage_col, commit
  );

endinterface
`default_nettype wire

// File: rtl/cursor_step_ctrl_btn_edge_detect.sv
`default_nettype none
// ============================================================================
// Module   : cursor_step_ctrl_btn_edge_detect
// Brief    : Rising-edge detector for one debounced button level.
//            rise = level AND NOT previous-cycle level.
// Revision : 1.0  initial release
// ============================================================================
module cursor_step_ctrl_btn_edge_detect (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic btn,
  output logic      rise
);

  logic prev_q;
  logic prev_d;

  // Previous level is tracked every cycle regardless of sequencer state
  always_comb begin
    prev_d = btn;
  end

  // Previous-level register
  always_ff @(posedge clk) begin
    if (rst) prev_q <= 1'b0;
    else     prev_q <= prev_d;
  end

  assign rise = btn & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/cursor_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cursor_step_ctrl
// Brief    : Turns button edges into row/column step commands for the VDC
//            position counters, keeps saturating shadow coordinates and runs
//            the row-select / column-select / commit flow.
// Options  : CURSOR_AUTO_REPEAT_EN - held direction button auto-repeats
//            every REPEAT_CYCLES idle cycles.
// Revision : 1.0  initial release
// ============================================================================
module cursor_step_ctrl
  import cursor_step_ctrl_pkg::*;
#(
  parameter int COUNT_WIRES   = DEF_COUNT_WIRES,
  parameter int INIT_ROW      = 0,
  parameter int INIT_COL      = 0,
  parameter int REPEAT_CYCLES = 16
) (
  input wire logic         clk,
  input wire logic         rst,
  cursor_step_ctrl_if.slave bus
);

  localparam logic [COUNT_WIRES-1:0] POS_MAX = COUNT_WIRES'(grid_max(COUNT_WIRES));
  localparam logic [COUNT_WIRES-1:0] ROW_RST = COUNT_WIRES'(INIT_ROW);
  localparam logic [COUNT_WIRES-1:0] COL_RST = COUNT_WIRES'(INIT_COL);

  logic [NUM_BTNS-1:0] btn_lvl;
  logic [NUM_BTNS-1:0] btn_rise;
  logic [NUM_BTNS-1:0] ev;

  assign btn_lvl = {bus.btn_sel, bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};

  for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_edge
    cursor_step_ctrl_btn_edge_detect u_edge (
      .clk  (clk),
      .rst  (rst),
      .btn  (btn_lvl[gi]),
      .rise (btn_rise[gi])
    );
  end

  // Edges are still registered under lock; only the events are suppressed
  assign ev = btn_rise & {NUM_BTNS{~bus.lock}};

  state_e                 state_q, state_d;
  state_e                 ret_q, ret_d;
  logic                   row_en_q, row_en_d;
  logic                   col_en_q, col_en_d;
  logic                   add_n_q, add_n_d;
  logic [COUNT_WIRES-1:0] row_q, row_d;
  logic [COUNT_WIRES-1:0] col_q, col_d;

  logic rep_up, rep_down, rep_left, rep_right;

`ifdef CURSOR_AUTO_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  dir_e             rep_dir_q, rep_dir_d;
  logic             rep_fire;
  logic             hold_vld;
  dir_e             hold_dir;
  logic             axis_col;
  logic             in_step;

  // Hold counter: counts while one active-axis direction is held, frozen
  // during the pulse/gap, restarted on release, lock, direction or stage change
  always_comb begin
    rep_cnt_d = rep_cnt_q;
    rep_dir_d = rep_dir_q;
    rep_fire  = 1'b0;
    hold_vld  = 1'b0;
    hold_dir  = DIR_UP;
    in_step   = (state_q == S_PULSE) || (state_q == S_GAP);
    axis_col  = (state_q == S_COL) || (in_step && (ret_q == S_COL));
    if (!axis_col) begin
      hold_vld = bus.btn_up ^ bus.btn_down;
      hold_dir = bus.btn_up ? DIR_UP : DIR_DOWN;
    end else begin
      hold_vld = bus.btn_left ^ bus.btn_right;
      hold_dir = bus.btn_left ? DIR_LEFT : DIR_RIGHT;
    end
    if (bus.lock || !hold_vld || (state_q == S_COMMIT) || (hold_dir != rep_dir_q)) begin
      rep_cnt_d = '0;
      rep_dir_d = hold_dir;
    end else if (!in_step) begin
      if (ev[BTN_SEL]) begin
        rep_cnt_d = '0;
      end else if (rep_cnt_q == REP_LAST) begin
        rep_fire  = 1'b1;
        rep_cnt_d = '0;
      end else begin
        rep_cnt_d = rep_cnt_q + 1'b1;
      end
    end
  end

  // Hold counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rep_cnt_q <= '0;
      rep_dir_q <= DIR_UP;
    end else begin
      rep_cnt_q <= rep_cnt_d;
      rep_dir_q <= rep_dir_d;
    end
  end

  assign rep_up    = rep_fire && (rep_dir_q == DIR_UP);
  assign rep_down  = rep_fire && (rep_dir_q == DIR_DOWN);
  assign rep_left  = rep_fire && (rep_dir_q == DIR_LEFT);
  assign rep_right = rep_fire && (rep_dir_q == DIR_RIGHT);
`else
  // No repeat moves in this build; REPEAT_CYCLES stays referenced so the
  // parameter list is identical in both builds (the compare is always false)
  assign {rep_up, rep_down, rep_left, rep_right} = {4{REPEAT_CYCLES < 0}};
`endif

  logic row_inc, row_dec, col_inc, col_dec;
  assign row_inc = ev[DIR_DOWN]  | rep_down;
  assign row_dec = ev[DIR_UP]    | rep_up;
  assign col_inc = ev[DIR_RIGHT] | rep_right;
  assign col_dec = ev[DIR_LEFT]  | rep_left;

  // Next-state, step command and shadow coordinate update
  always_comb begin
    state_d  = state_q;
    ret_d    = ret_q;
    row_en_d = row_en_q;
    col_en_d = col_en_q;
    add_n_d  = add_n_q;
    row_d    = row_q;
    col_d    = col_q;
    case (state_q)
      S_ROW: begin
        if (ev[BTN_SEL]) begin
          state_d = S_COL;
        end else if (row_inc && !row_dec && (row_q != POS_MAX)) begin
          row_d = row_q + 1'b1; row_en_d = 1'b1; add_n_d = 1'b0;
          ret_d = S_ROW;        state_d  = S_PULSE;
        end else if (row_dec && !row_inc && (row_q != '0)) begin
          row_d = row_q - 1'b1; row_en_d = 1'b1; add_n_d = 1'b1;
          ret_d = S_ROW;        state_d  = S_PULSE;
        end
      end
      S_COL: begin
        if (ev[BTN_SEL]) begin
          state_d = S_COMMIT;
        end else if (col_inc && !col_dec && (col_q != POS_MAX)) begin
          col_d = col_q + 1'b1; col_en_d = 1'b1; add_n_d = 1'b0;
          ret_d = S_COL;        state_d  = S_PULSE;
        end else if (col_dec && !col_inc && (col_q != '0)) begin
          col_d = col_q - 1'b1; col_en_d = 1'b1; add_n_d = 1'b1;
          ret_d = S_COL;        state_d  = S_PULSE;
        end
      end
      S_PULSE: state_d = S_GAP;
      S_GAP: begin
        state_d  = ret_q;
        row_en_d = 1'b0;
        col_en_d = 1'b0;
        add_n_d  = 1'b0;
      end
      S_COMMIT: state_d = S_ROW;
      default:  state_d = S_ROW;
    endcase
  end

  // Sequencer state, return state, step command and shadow coordinates
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_ROW;
      ret_q    <= S_ROW;
      row_en_q <= 1'b0;
      col_en_q <= 1'b0;
      add_n_q  <= 1'b0;
      row_q    <= ROW_RST;
      col_q    <= COL_RST;
    end else begin
      state_q  <= state_d;
      ret_q    <= ret_d;
      row_en_q <= row_en_d;
      col_en_q <= col_en_d;
      add_n_q  <= add_n_d;
      row_q    <= row_d;
      col_q    <= col_d;
    end
  end

  assign bus.row_en    = row_en_q;
  assign bus.col_en    = col_en_q;
  assign bus.add_n     = add_n_q;
  assign bus.fire      = (state_q == S_PULSE);
  assign bus.commit    = (state_q == S_COMMIT);
  assign bus.row_pos   = row_q;
  assign bus.col_pos   = col_q;
  assign bus.stage_col = (state_q == S_COL) ||
                         (((state_q == S_PULSE) || (state_q == S_GAP)) && (ret_q == S_COL));

endmodule
`default_nettype wire

// File: tb/tb_cursor_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cursor_step_ctrl
// Brief    : Directed self-checking bench for cursor_step_ctrl.
// Options  : CURSOR_AUTO_REPEAT_EN enables the auto-repeat vector.
// Revision : 1.0  initial release
// ============================================================================
module tb_cursor_step_ctrl;
  import cursor_step_ctrl_pkg::*;

  localparam int CW = 2;
  localparam int RC = 16;

  localparam int B_UP = 0, B_DOWN = 1, B_LEFT = 2, B_RIGHT = 3, B_SEL = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  cursor_step_ctrl_if #(.COUNT_WIRES(CW)) bus ();

  cursor_step_ctrl #(
    .COUNT_WIRES   (CW),
    .INIT_ROW      (0),
    .INIT_COL      (0),
    .REPEAT_CYCLES (RC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk    = 0;
  int n_pass   = 0;
  int fire_cnt = 0;
  int b2b_cnt  = 0;
  int fc0;
  logic prev_fire = 1'b0;

  // Fire monitor: total pulses and back-to-back violations
  always @(negedge clk) begin
    if (bus.fire === 1'b1) begin
      fire_cnt++;
      if (prev_fire) b2b_cnt++;
    end
    prev_fire = (bus.fire === 1'b1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      B_UP:    bus.btn_up    = v;
      B_DOWN:  bus.btn_down  = v;
      B_LEFT:  bus.btn_left  = v;
      B_RIGHT: bus.btn_right = v;
      default: bus.btn_sel   = v;
    endcase
  endtask

  // Press for one cycle, then allow pulse, gap and idle to elapse
  task automatic step(input int b);
    set_btn(b, 1'b1);
    tick();
    set_btn(b, 1'b0);
    ticks(2);
  endtask

  initial begin
    bus.btn_up = 0; bus.btn_down = 0; bus.btn_left = 0;
    bus.btn_right = 0; bus.btn_sel = 0; bus.lock = 0;
    rst = 1'b1;
    ticks(3);
    rst = 1'b0;
    tick();
    chk("rst_row_pos",   bus.row_pos,   0);
    chk("rst_col_pos",   bus.col_pos,   0);
    chk("rst_fire",      bus.fire,      0);
    chk("rst_stage_col", bus.stage_col, 0);
    chk("rst_commit",    bus.commit,    0);
    chk("rst_row_en",    bus.row_en,    0);

    // First step: fire one cycle after the edge
    set_btn(B_DOWN, 1); tick();
    chk("down_fire",    bus.fire,    1);
    chk("down_row_en",  bus.row_en,  1);
    chk("down_col_en",  bus.col_en,  0);
    chk("down_add_n",   bus.add_n,   0);
    chk("down_row_pos", bus.row_pos, 1);
    set_btn(B_DOWN, 0); tick();
    chk("gap_fire",     bus.fire,    0);
    chk("gap_row_en",   bus.row_en,  1);
    tick();
    chk("idle_row_en",  bus.row_en,  0);

    // Saturation at the bottom row
    step(B_DOWN); step(B_DOWN);
    chk("row_at_max", bus.row_pos, 3);
    set_btn(B_DOWN, 1); tick();
    chk("sat_inc_fire", bus.fire,    0);
    chk("sat_inc_row",  bus.row_pos, 3);
    set_btn(B_DOWN, 0); tick();

    // Column selection and commit
    step(B_SEL);
    chk("sel_stage_col", bus.stage_col, 1);
    set_btn(B_RIGHT, 1); tick();
    chk("right_col_en",  bus.col_en,    1);
    chk("right_row_en",  bus.row_en,    0);
    chk("right_add_n",   bus.add_n,     0);
    chk("right_col_pos", bus.col_pos,   1);
    chk("right_stage",   bus.stage_col, 1);
    set_btn(B_RIGHT, 0); ticks(2);
    step(B_RIGHT);
    chk("col_two", bus.col_pos, 2);
    set_btn(B_SEL, 1); tick();
    chk("commit_pulse",   bus.commit,    1);
    chk("commit_row",     bus.row_pos,   3);
    chk("commit_col",     bus.col_pos,   2);
    chk("commit_stage",   bus.stage_col, 0);
    set_btn(B_SEL, 0); tick();
    chk("commit_one_cyc", bus.commit,    0);
    chk("post_commit_stage", bus.stage_col, 0);
    set_btn(B_UP, 1); tick();
    chk("up_fire",    bus.fire,    1);
    chk("up_row_en",  bus.row_en,  1);
    chk("up_add_n",   bus.add_n,   1);
    chk("up_row_pos", bus.row_pos, 2);
    set_btn(B_UP, 0); ticks(2);

    // Edge during the pulse is dropped
    fc0 = fire_cnt;
    set_btn(B_UP, 1); tick();
    set_btn(B_DOWN, 1); tick();
    set_btn(B_UP, 0); set_btn(B_DOWN, 0); ticks(3);
    chk("overlap_row",   bus.row_pos, 1);
    chk("overlap_fires", fire_cnt - fc0, 1);

    // Lock suppresses events
    bus.lock = 1;
    set_btn(B_DOWN, 1); tick();
    chk("lock_fire", bus.fire, 0);
    set_btn(B_DOWN, 0); tick();
    bus.lock = 0; tick();
    chk("lock_row", bus.row_pos, 1);

    // sel beats a move
    set_btn(B_SEL, 1); set_btn(B_DOWN, 1); tick();
    chk("selmove_stage", bus.stage_col, 1);
    chk("selmove_fire",  bus.fire,      0);
    chk("selmove_row",   bus.row_pos,   1);
    set_btn(B_SEL, 0); set_btn(B_DOWN, 0); tick();

    // Opposing moves and inactive-axis moves are dropped
    set_btn(B_LEFT, 1); set_btn(B_RIGHT, 1); tick();
    chk("oppose_fire", bus.fire,    0);
    chk("oppose_col",  bus.col_pos, 2);
    set_btn(B_LEFT, 0); set_btn(B_RIGHT, 0); tick();
    set_btn(B_DOWN, 1); tick();
    chk("inactive_fire", bus.fire,    0);
    chk("inactive_row",  bus.row_pos, 1);
    set_btn(B_DOWN, 0); tick();

    // Saturation at column 0
    step(B_LEFT); step(B_LEFT);
    chk("col_zero", bus.col_pos, 0);
    set_btn(B_LEFT, 1); tick();
    chk("sat_dec_fire", bus.fire,    0);
    chk("sat_dec_col",  bus.col_pos, 0);
    set_btn(B_LEFT, 0); tick();

    // Reset during a pulse aborts the step
    set_btn(B_RIGHT, 1); tick();
    chk("pre_rst_fire", bus.fire,    1);
    chk("pre_rst_col",  bus.col_pos, 1);
    set_btn(B_RIGHT, 0);
    rst = 1'b1; tick();
    chk("midrst_fire",   bus.fire,      0);
    chk("midrst_col",    bus.col_pos,   0);
    chk("midrst_row",    bus.row_pos,   0);
    chk("midrst_stage",  bus.stage_col, 0);
    chk("midrst_col_en", bus.col_en,    0);
    rst = 1'b0; tick();

`ifdef CURSOR_AUTO_REPEAT_EN
    // Held right button: press step plus repeats, saturating at 3
    step(B_SEL);
    fc0 = fire_cnt;
    set_btn(B_RIGHT, 1); ticks(40);
    set_btn(B_RIGHT, 0); ticks(3);
    chk("repeat_col",   bus.col_pos, 3);
    chk("repeat_fires", fire_cnt - fc0, 3);
`endif

    chk("no_back_to_back_fire", b2b_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cursor_step_ctrl.md
Name: cursor_step_ctrl

Overview:
Sequencer for the row and column position counters that drive the VDC one-hot decoders. It turns already-debounced button levels into correctly formed step commands (row_en/col_en, add_n, single-cycle fire pulses with a guaranteed low gap). It keeps shadow copies of both coordinates so it can saturate at the grid edges. The selection flow is: row select, then column select, then commit of the chosen cell to game logic.

Parameters:
COUNT_WIRES, 2, coordinate width; must match downstream counter width
INIT_ROW, 0, reset row; downstream row counter load must be tied to the same value
INIT_COL, 0, reset column; downstream column counter load must be tied to the same value
REPEAT_CYCLES, 16, hold time in clk cycles per auto-repeat step; used only with the optional feature

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
btn_up  in  1  decrement row, level
btn_down  in  1  increment row, level
btn_left  in  1  decrement column, level
btn_right  in  1  increment column, level
btn_sel  in  1  advance selection stage, level
lock  in  1  ignore all button events while high (opponent turn)
row_en  out  1  step targets row counter
col_en  out  1  step targets column counter
add_n  out  1  0 = increment, 1 = decrement
fire  out  1  step strobe to counters
row_pos  out  COUNT_WIRES  shadow row coordinate
col_pos  out  COUNT_WIRES  shadow column coordinate
stage_col  out  1  1 while column is being selected
commit  out  1  one-cycle pulse; row_pos/col_pos valid for the chosen cell

Behaviour:
- Event detection: rising edge of each button, computed as level AND NOT previous-cycle level. Previous-cycle registers update every cycle in every state. Events are dropped while lock=1.
- States:
  - S_ROW (reset state): up/down events move the row.
  - S_COL: left/right events move the column.
  - S_PULSE: fire=1 for exactly one cycle.
  - S_GAP: fire=0 for one cycle, then return to the originating state (held in a return register).
  - S_COMMIT: commit=1 for one cycle, then S_ROW.
- Move accepted from S_ROW or S_COL:
  - Set row_en or col_en, and set add_n (down/right -> 0, up/left -> 1).
  - Update the shadow coordinate on entry to S_PULSE.
  - row_en/col_en/add_n hold stable through S_PULSE and S_GAP and drop to 0 on return.
- Saturation (no wrap-around):
  - An increment at 2^COUNT_WIRES-1 is discarded; no pulse is issued.
  - A decrement at 0 is discarded; no pulse is issued.
- btn_sel event: S_ROW -> S_COL; S_COL -> S_COMMIT.
- Event priority in the same cycle:
  - sel beats a move; the move is dropped.
  - Opposing moves together (up+down, or left+right) are both dropped.
  - Moves for the inactive axis are ignored.
- Events arriving during S_PULSE, S_GAP or S_COMMIT are dropped; there is no queuing.
- Minimum step spacing is 3 cycles: pulse, gap, idle. fire is never high on two consecutive cycles.
- stage_col = 1 in S_COL, and in S_PULSE/S_GAP when the return state is S_COL.
- Reset values: state S_ROW, all strobes/enables/add_n = 0, row_pos = INIT_ROW, col_pos = INIT_COL, edge registers = 0.
- Reset mid-pulse aborts the step the next cycle. The downstream counters reload, so the coordinates stay consistent.
- lock rising while in S_PULSE/S_GAP: the current step completes; subsequent events are dropped.
- Latency: button edge cycle N -> fire high at cycle N+1.

Optional Feature:
- Macro CURSOR_AUTO_REPEAT_EN.
- Defined:
  - A per-direction hold counter runs while one active-axis direction button is held steadily in S_ROW/S_COL, with no opposing button and lock=0.
  - The counter counts only while in S_ROW/S_COL and freezes during S_PULSE/S_GAP.
  - Each time it reaches REPEAT_CYCLES, an extra move is issued and the counter restarts from 0.
  - Saturation and priority rules apply unchanged.
  - The counter clears on release, on lock, on a stage change, and on rst.
- Undefined: the counter logic is absent; each press yields at most one step.

Decomposition:
- Shared package holds:
  - state encoding constants (S_ROW, S_COL, S_PULSE, S_GAP, S_COMMIT);
  - direction codes;
  - default COUNT_WIRES;
  - the GRID_MAX = 2^COUNT_WIRES-1 constant.
- One natural sub-module: btn_edge_detect, a per-button registered rising-edge detector instantiated 5x.
- The repeat counter stays inline under the macro.

Test Plan:
- Reset with INIT_ROW=0 -> row_pos=0, col_pos=0, fire=0, stage_col=0; then btn_down edge -> fire at N+1 with row_en=1, add_n=0, row_pos=1.
- 4 separate btn_down presses from row 0 -> 3 pulses, row_pos=3; 4th press gives no fire and row_pos stays 3.
- btn_sel, then btn_right twice, then btn_sel -> stage_col=1, col_pos=2, then a one-cycle commit with row_pos=3, col_pos=2, then stage S_ROW.
- btn_up edge in cycle N and btn_down edge in cycle N+1 -> only one pulse issued; fire never high on 2 consecutive cycles.
- lock=1 with btn_down pressed -> no fire; sel and down edges in the same cycle -> stage_col=1 with no pulse.
- With CURSOR_AUTO_REPEAT_EN and REPEAT_CYCLES=16, btn_right held 40 cycles from col 0 -> col_pos=3 (press step plus repeats, saturated), no wrap to 0.
